// File: rtl/press_classifier.sv
// -----------------------------------------------------------------------------
// press_classifier
//
// Purpose:
//   Classifies gestures on a debounced, already-synchronous button level as
//   SHORT, LONG or DOUBLE presses. Each class produces a registered one-cycle
//   pulse, and a wrapping counter tracks the number of classified events.
//   The input is assumed clean, so no synchronizer or debouncer is built in.
//
// Configuration macro:
//   PRESS_REPEAT_EN - when defined, a second counter generates repeatPress
//                     every REPEAT_CYCLES cycles while a long press is held.
//                     When undefined, repeatPress is tied low. Both builds
//                     have the same port list.
//
// Ports:
//   clk                in   1            system clock, rising edge
//   resetN             in   1            asynchronous active-low reset
//   conditionedSignal  in   1            debounced button level, 1 = pressed
//   shortPress         out  1            pulse: single short press
//   longPress          out  1            pulse: hold reached LONG_CYCLES
//   doublePress        out  1            pulse: second press released
//   repeatPress        out  1            pulse: auto-repeat while long-held
//   eventCount         out  COUNT_WIDTH  short/long/double events since reset
// -----------------------------------------------------------------------------
module press_classifier #(
    parameter int unsigned LONG_CYCLES       = 50_000_000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 12_500_000,
    parameter int unsigned REPEAT_CYCLES     = 10_000_000,
    parameter int unsigned COUNT_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   conditionedSignal,
    output logic                   shortPress,
    output logic                   longPress,
    output logic                   doublePress,
    output logic                   repeatPress,
    output logic [COUNT_WIDTH-1:0] eventCount
);

    // One timer serves every timed state, so it is sized for the longest
    // interval the block has to measure.
    localparam int unsigned MAX_LG     = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ?
                                         LONG_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int          TIMER_W    = $clog2(MAX_CYCLES) + 1;

    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_HELD
    } state_e;

    state_e                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   prev_level_q;
    logic                   rise, fall;

    logic                   short_d, long_d, double_d, repeat_d;
    logic                   short_q, long_q, double_q, repeat_q;
    logic [COUNT_WIDTH-1:0] count_q;

    // Edge detection against the previous level. prev_level_q resets to 0, so
    // a button held through reset release is seen as a fresh press.
    assign rise = conditionedSignal & ~prev_level_q;
    assign fall = ~conditionedSignal & prev_level_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            prev_level_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            prev_level_q <= conditionedSignal;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default on entry; a path that left
    // one unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = HELD;
            end
            HELD: begin
                // A release on the timeout edge wins: the gesture stays short.
                if (fall)                    state_d = WAIT_SECOND;
                else if (timer_q == LONG_LAST) state_d = LONG_HELD;
            end
            LONG_HELD: begin
                if (fall) state_d = IDLE;
            end
            WAIT_SECOND: begin
                // A press on the timeout edge wins: the gesture becomes a double.
                if (rise)                     state_d = SECOND_HELD;
                else if (timer_q == GAP_LAST) state_d = IDLE;
            end
            SECOND_HELD: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timer restarts on every state change, counts only in the timed
        // states, and saturates instead of wrapping.
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == HELD || state_q == WAIT_SECOND) && timer_q != TIMER_MAX) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (pre-register pulse decisions)
    // -------------------------------------------------------------------------
    always_comb begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        unique case (state_q)
            HELD:        long_d   = ~fall & (timer_q == LONG_LAST);
            WAIT_SECOND: short_d  = ~rise & (timer_q == GAP_LAST);
            SECOND_HELD: double_d = fall;
            default: ;
        endcase
    end

`ifdef PRESS_REPEAT_EN
    // Auto-repeat: counts only while long-held, restarts on every pulse and
    // clears as soon as the state is left. The first pulse lands
    // REPEAT_CYCLES cycles after the longPress pulse.
    localparam int               REP_W    = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_q, rep_d;

    always_comb begin
        rep_d    = '0;
        repeat_d = 1'b0;
        if (state_q == LONG_HELD) begin
            repeat_d = (rep_q == REP_LAST);
            if (state_d == LONG_HELD) begin
                rep_d = (rep_q == REP_LAST) ? '0 : rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rep_q <= '0;
        else         rep_q <= rep_d;
    end
`else
    assign repeat_d = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Registered outputs and event counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            repeat_q <= 1'b0;
            count_q  <= '0;
        end else begin
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            repeat_q <= repeat_d;
            // Repeats are deliberately not counted; the counter wraps freely.
            if (short_d | long_d | double_d) count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign shortPress  = short_q;
    assign longPress   = long_q;
    assign doublePress = double_q;
    assign repeatPress = repeat_q;
    assign eventCount  = count_q;

endmodule

// File: tb/tb_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_press_classifier
//
// Directed bench for press_classifier with small timing parameters. Expected
// pulses (kind, cycle, event count) are queued when the stimulus is driven
// and compared by a monitor on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_press_classifier;

    localparam int LONG = 20;
    localparam int GAP  = 10;
    localparam int REP  = 5;
    localparam int CW   = 4;

    localparam logic [3:0] P_SHORT  = 4'b0001;
    localparam logic [3:0] P_LONG   = 4'b0010;
    localparam logic [3:0] P_DOUBLE = 4'b0100;
    localparam logic [3:0] P_REPEAT = 4'b1000;

    typedef struct {
        logic [3:0]    pulses;
        int            cyc;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          conditionedSignal = 1'b0;
    logic          shortPress, longPress, doublePress, repeatPress;
    logic [CW-1:0] eventCount;

    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fail = 0;
    exp_t sb[$];

    press_classifier #(
        .LONG_CYCLES      (LONG),
        .DOUBLE_GAP_CYCLES(GAP),
        .REPEAT_CYCLES    (REP),
        .COUNT_WIDTH      (CW)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .conditionedSignal(conditionedSignal),
        .shortPress       (shortPress),
        .longPress        (longPress),
        .doublePress      (doublePress),
        .repeatPress      (repeatPress),
        .eventCount       (eventCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] p, input int c, input int cnt);
        exp_t e;
        e.pulses = p;
        e.cyc    = c;
        e.cnt    = CW'(cnt);
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse must match the head of the scoreboard in cycle, kind
    // and resulting event count; a due entry with no pulse is a miss.
    always @(negedge clk) begin
        logic [3:0] obs;
        exp_t       e;
        obs = {repeatPress, doublePress, longPress, shortPress};
        if (resetN) begin
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("pulse_kind", 32'(obs), 32'(e.pulses));
                check("pulse_count", 32'(eventCount), 32'(e.cnt));
            end else if (obs != 4'b0000) begin
                check("unexpected_pulse", 32'(obs), 32'(0));
            end
        end
    end

    initial begin
        // Reset state
        tick(2);
        check("rst_short", 32'(shortPress), 0);
        check("rst_long", 32'(longPress), 0);
        check("rst_double", 32'(doublePress), 0);
        check("rst_repeat", 32'(repeatPress), 0);
        check("rst_count", 32'(eventCount), 0);
        resetN = 1'b1;
        tick(2);

        // 1: 5-cycle press -> SHORT GAP cycles after the fall is accepted
        conditionedSignal = 1'b1;
        tick(5);
        conditionedSignal = 1'b0;
        push(P_SHORT, cyc + 1 + GAP, 1);
        tick(20);
        check("t1_count", 32'(eventCount), 1);

        // 2: 30-cycle hold -> LONG LONG cycles after the rise is accepted
        conditionedSignal = 1'b1;
        push(P_LONG, cyc + 1 + LONG, 2);
`ifdef PRESS_REPEAT_EN
        push(P_REPEAT, cyc + 1 + LONG + REP, 2);
        push(P_REPEAT, cyc + 1 + LONG + 2 * REP, 2);
`endif
        tick(30);
        conditionedSignal = 1'b0;
        tick(15);
        check("t2_count", 32'(eventCount), 2);

        // 3: press 3, gap 4, press 3 -> DOUBLE one cycle after second fall
        conditionedSignal = 1'b1;
        tick(3);
        conditionedSignal = 1'b0;
        tick(4);
        conditionedSignal = 1'b1;
        tick(3);
        conditionedSignal = 1'b0;
        push(P_DOUBLE, cyc + 1, 3);
        tick(15);
        check("t3_count", 32'(eventCount), 3);

        // 4a: fall accepted on the edge where the hold timer is LONG-1
        conditionedSignal = 1'b1;
        tick(LONG);
        conditionedSignal = 1'b0;
        push(P_SHORT, cyc + 1 + GAP, 4);
        tick(15);
        check("t4a_count", 32'(eventCount), 4);

        // 4b: second rise accepted on the edge where the gap timer is GAP-1
        conditionedSignal = 1'b1;
        tick(3);
        conditionedSignal = 1'b0;
        tick(GAP);
        conditionedSignal = 1'b1;
        tick(3);
        conditionedSignal = 1'b0;
        push(P_DOUBLE, cyc + 1, 5);
        tick(15);
        check("t4b_count", 32'(eventCount), 5);

        // 5: from a fresh reset, 17 shorts wrap the 4-bit count 15 -> 0 -> 1
        resetN = 1'b0;
        tick(1);
        check("t5_rst_count", 32'(eventCount), 0);
        resetN = 1'b1;
        tick(2);
        for (int k = 0; k < 17; k++) begin
            conditionedSignal = 1'b1;
            tick(2);
            conditionedSignal = 1'b0;
            push(P_SHORT, cyc + 1 + GAP, (k + 1) % 16);
            tick(GAP + 3);
        end
        check("t5_wrap_count", 32'(eventCount), 1);

        // 6: one-cycle reset during HELD aborts silently; level re-detected
        conditionedSignal = 1'b1;
        tick(5);
        resetN = 1'b0;
        #1;
        check("t6_rst_short", 32'(shortPress), 0);
        check("t6_rst_long", 32'(longPress), 0);
        check("t6_rst_double", 32'(doublePress), 0);
        check("t6_rst_repeat", 32'(repeatPress), 0);
        check("t6_rst_count", 32'(eventCount), 0);
        tick(1);
        resetN = 1'b1;
        push(P_LONG, cyc + 1 + LONG, 1);
        tick(LONG + 3);
        conditionedSignal = 1'b0;
        tick(15);
        check("t6_count", 32'(eventCount), 1);

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
